// File: rtl/ms_loader.sv
// Program loader for the PATP main store: takes a framed byte stream (length, payload,
// checksum), writes the payload from address 0 up and releases the core on a good checksum.
module ms_loader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              ms_write,
    output logic [ADDR_W-1:0] ms_addr,
    output logic [DATA_W-1:0] ms_data,
    output logic              core_rst,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_RUN   = 2'd3;

    localparam logic [DATA_W-1:0] DEPTH_B = DATA_W'(DEPTH);
    localparam logic [DATA_W-1:0] ONE_B   = {{(DATA_W-1){1'b0}}, 1'b1};

    // A frame is good when length + payload + checksum wraps to zero.
    function automatic logic checksum_ok(input logic [DATA_W-1:0] sum, input logic [DATA_W-1:0] c);
        logic [DATA_W-1:0] total;
        total = sum + c;
        return (total == {DATA_W{1'b0}});
    endfunction

    logic [1:0]        state_r;
    logic [DATA_W-1:0] len_r;
    logic [DATA_W-1:0] sum_r;
    logic [ADDR_W-1:0] cnt_r;

    logic              xfer_s;
    logic              len_ok_s;
    logic              last_s;
    logic [DATA_W-1:0] sum_next_s;

    assign xfer_s = in_valid && in_ready;

    // Decode of the incoming byte against the current frame position.
    always_comb begin
        len_ok_s   = (in_data != {DATA_W{1'b0}}) && (in_data <= DEPTH_B);
        sum_next_s = sum_r + in_data;
        last_s     = ({{(DATA_W-ADDR_W){1'b0}}, cnt_r} == (len_r - ONE_B));
    end

    // Frame state machine and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            len_r    <= {DATA_W{1'b0}};
            sum_r    <= {DATA_W{1'b0}};
            cnt_r    <= {ADDR_W{1'b0}};
            in_ready <= 1'b0;
            ms_write <= 1'b0;
            ms_addr  <= {ADDR_W{1'b0}};
            ms_data  <= {DATA_W{1'b0}};
            core_rst <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            ms_write <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    in_ready <= 1'b1;
                    if (xfer_s) begin
                        if (len_ok_s) begin
                            len_r   <= in_data;
                            sum_r   <= in_data;
                            cnt_r   <= {ADDR_W{1'b0}};
                            err     <= 1'b0;
                            state_r <= ST_LOAD;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    in_ready <= 1'b1;
                    if (xfer_s) begin
                        ms_write <= 1'b1;
                        ms_addr  <= cnt_r;
                        ms_data  <= in_data;
                        sum_r    <= sum_next_s;
                        // cnt_r saturates at the last address; it is never used past it.
                        if (last_s) begin
                            state_r <= ST_CHECK;
                        end else begin
                            cnt_r <= cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                ST_CHECK: begin
                    if (xfer_s) begin
                        if (checksum_ok(sum_r, in_data)) begin
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                            core_rst <= 1'b0;
                            state_r  <= ST_RUN;
                        end else begin
                            in_ready <= 1'b1;
                            err      <= 1'b1;
                            state_r  <= ST_IDLE;
                        end
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (reload) begin
                        in_ready <= 1'b1;
                        done     <= 1'b0;
                        core_rst <= 1'b1;
                        state_r  <= ST_IDLE;
                    end else begin
                        in_ready <= 1'b0;
                    end
                end
                default: begin
                    in_ready <= 1'b0;
                    done     <= 1'b0;
                    core_rst <= 1'b1;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ms_loader.sv
// Directed plus randomized bench for ms_loader; expectations come from the frame rules
// (length range, modulo-256 checksum, payload k lands at address k).
module tb_ms_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       reload;
    logic       ms_write;
    logic [4:0] ms_addr;
    logic [7:0] ms_data;
    logic       core_rst;
    logic       done;
    logic       err;

    ms_loader #(.ADDR_W(5), .DATA_W(8), .DEPTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .reload(reload), .ms_write(ms_write), .ms_addr(ms_addr), .ms_data(ms_data),
        .core_rst(core_rst), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [4:0] a;
        logic [7:0] d;
        int         c;
    } wr_t;

    wr_t        wq[$];
    logic [7:0] pay[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ms_write === 1'b1) wq.push_back('{ms_addr, ms_data, cyc});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called and returns at a negedge; holds the byte until accepted.
    task automatic send(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) begin
            in_data = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    function automatic logic [7:0] good_cks(input logic [7:0] len);
        int s;
        s = int'(len);
        foreach (pay[i]) s += int'(pay[i]);
        return 8'((256 - (s % 256)) % 256);
    endfunction

    // Sends L, the payload in pay[], then c; checks writes and final flags.
    task automatic run_frame(input string tag, input logic [7:0] len, input logic [7:0] c,
                             input int maxgap);
        int  s;
        bit  len_ok;
        bit  ok;
        len_ok = (len >= 8'd1) && (len <= 8'd32);
        wq.delete();
        send(len, $urandom_range(0, maxgap));
        if (!len_ok) begin
            chk({tag, "_err_badlen"}, {31'd0, err}, 32'd1);
            chk({tag, "_ready_badlen"}, {31'd0, in_ready}, 32'd1);
            chk({tag, "_nowrite_badlen"}, wq.size(), 32'd0);
            chk({tag, "_coreRst_badlen"}, {31'd0, core_rst}, 32'd1);
        end else begin
            chk({tag, "_err_cleared"}, {31'd0, err}, 32'd0);
            foreach (pay[i]) send(pay[i], $urandom_range(0, maxgap));
            send(c, $urandom_range(0, maxgap));
            s = int'(len) + int'(c);
            foreach (pay[i]) s += int'(pay[i]);
            ok = ((s % 256) == 0);
            chk({tag, "_nwrites"}, wq.size(), int'(len));
            foreach (wq[k]) begin
                if (k < pay.size()) begin
                    chk({tag, "_addr"}, {27'd0, wq[k].a}, k);
                    chk({tag, "_data"}, {24'd0, wq[k].d}, {24'd0, pay[k]});
                    if (maxgap == 0) chk({tag, "_b2b"}, wq[k].c, wq[0].c + k);
                end
            end
            chk({tag, "_done"}, {31'd0, done}, {31'd0, ok});
            chk({tag, "_core_rst"}, {31'd0, core_rst}, {31'd0, !ok});
            chk({tag, "_in_ready"}, {31'd0, in_ready}, {31'd0, !ok});
            chk({tag, "_err"}, {31'd0, err}, {31'd0, !ok});
        end
    endtask

    task automatic do_reload(input string tag);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        chk({tag, "_reload_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_reload_core_rst"}, {31'd0, core_rst}, 32'd1);
        chk({tag, "_reload_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_write"}, {31'd0, ms_write}, 32'd0);
        chk({tag, "_addr"}, {27'd0, ms_addr}, 32'd0);
        chk({tag, "_data"}, {24'd0, ms_data}, 32'd0);
        chk({tag, "_core_rst"}, {31'd0, core_rst}, 32'd1);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    initial begin
        logic [7:0] len;
        logic [7:0] c;
        rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; reload = 1'b0;

        // Asynchronous reset between edges.
        #3 rst = 1'b1;
        #1 chk_reset_vals("rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_release_ready0", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("rst_release_ready1", {31'd0, in_ready}, 32'd1);

        // Good load, back to back.
        pay = '{8'h21, 8'h42, 8'h63};
        run_frame("good", 8'h03, 8'h37, 0);

        // in_valid in RUN is ignored.
        wq.delete();
        in_valid = 1'b1; in_data = 8'h05;
        repeat (3) begin
            @(negedge clk);
            chk("run_ready0", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        chk("run_nowrite", wq.size(), 32'd0);
        chk("run_done_held", {31'd0, done}, 32'd1);
        do_reload("good");

        // Bad checksum.
        run_frame("badck", 8'h03, 8'h38, 0);

        // Length bounds, then an in-range length clears err.
        pay = '{};
        run_frame("len0", 8'h00, 8'h00, 0);
        run_frame("len33", 8'h21, 8'h00, 0);
        pay = '{8'hA5};
        run_frame("len1", 8'h01, good_cks(8'h01), 0);
        do_reload("len1");

        // Full-depth frame.
        pay = '{};
        for (int i = 0; i < 32; i++) pay.push_back(8'(i));
        run_frame("full", 8'd32, good_cks(8'd32), 0);
        chk("full_last_addr", {27'd0, wq[wq.size()-1].a}, 32'd31);
        do_reload("full");

        // Random frames with input gaps and random checksum corruption.
        for (int it = 0; it < 8; it++) begin
            len = 8'($urandom_range(1, 32));
            pay = '{};
            for (int i = 0; i < int'(len); i++) pay.push_back(8'($urandom));
            c = good_cks(len);
            if ($urandom_range(0, 2) == 0) c = c + 8'($urandom_range(1, 255));
            run_frame("rand", len, c, 3);
            if (done === 1'b1) do_reload("rand");
        end

        // Reset after the second payload byte.
        wq.delete();
        send(8'h05, 0);
        send(8'h11, 0);
        send(8'h22, 0);
        chk("midrst_write_pending", {31'd0, ms_write}, 32'd1);
        #2 rst = 1'b1;
        #1 chk_reset_vals("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pay = '{8'h77, 8'h88};
        run_frame("after_rst", 8'h02, good_cks(8'h02), 1);
        do_reload("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
